// File: rtl/simple_alu_pkg.sv
// Shared opcode map, flag layout and pipeline payload for simple_alu_pipe.
// Optional build macro ALU_OVF_EXC_EN is consumed by simple_alu_comb.
package simple_alu_pkg;

  localparam int OPC_PKG_W = 8;

  localparam logic [OPC_PKG_W-1:0] OP_NOP   = 8'h00;
  localparam logic [OPC_PKG_W-1:0] OP_ADD   = 8'h01;
  localparam logic [OPC_PKG_W-1:0] OP_ADDU  = 8'h02;
  localparam logic [OPC_PKG_W-1:0] OP_SUB   = 8'h03;
  localparam logic [OPC_PKG_W-1:0] OP_SUBU  = 8'h04;
  localparam logic [OPC_PKG_W-1:0] OP_AND   = 8'h05;
  localparam logic [OPC_PKG_W-1:0] OP_OR    = 8'h06;
  localparam logic [OPC_PKG_W-1:0] OP_XOR   = 8'h07;
  localparam logic [OPC_PKG_W-1:0] OP_NOR   = 8'h08;
  localparam logic [OPC_PKG_W-1:0] OP_SLT   = 8'h09;
  localparam logic [OPC_PKG_W-1:0] OP_SLTU  = 8'h0A;
  localparam logic [OPC_PKG_W-1:0] OP_SLL   = 8'h0B;
  localparam logic [OPC_PKG_W-1:0] OP_SRL   = 8'h0C;
  localparam logic [OPC_PKG_W-1:0] OP_SRA   = 8'h0D;
  localparam logic [OPC_PKG_W-1:0] OP_SLLV  = 8'h0E;
  localparam logic [OPC_PKG_W-1:0] OP_SRLV  = 8'h0F;
  localparam logic [OPC_PKG_W-1:0] OP_SRAV  = 8'h10;
  localparam logic [OPC_PKG_W-1:0] OP_ADDI  = 8'h11;
  localparam logic [OPC_PKG_W-1:0] OP_ADDIU = 8'h12;
  localparam logic [OPC_PKG_W-1:0] OP_ANDI  = 8'h13;
  localparam logic [OPC_PKG_W-1:0] OP_ORI   = 8'h14;
  localparam logic [OPC_PKG_W-1:0] OP_XORI  = 8'h15;
  localparam logic [OPC_PKG_W-1:0] OP_SLTI  = 8'h16;
  localparam logic [OPC_PKG_W-1:0] OP_SLTIU = 8'h17;
  localparam logic [OPC_PKG_W-1:0] OP_LUI   = 8'h18;
  localparam logic [OPC_PKG_W-1:0] OP_MFHI  = 8'h19;
  localparam logic [OPC_PKG_W-1:0] OP_MTHI  = 8'h1A;
  localparam logic [OPC_PKG_W-1:0] OP_MFLO  = 8'h1B;
  localparam logic [OPC_PKG_W-1:0] OP_MTLO  = 8'h1C;

  // flags = {rsvd, dest_wr, rsvd, executed, exception, mispredict}
  localparam int FLAG_MISPRED = 0;
  localparam int FLAG_EXC     = 1;
  localparam int FLAG_EXEC    = 2;
  localparam int FLAG_DEST_WR = 4;

  typedef logic [5:0] flags_t;

  // Payload fields sized for the widest supported build; narrower builds leave
  // the upper bits constant zero.
  localparam int PL_DATA_W = 64;
  localparam int PL_TAG_W  = 16;

  typedef struct packed {
    logic [PL_DATA_W-1:0] result;
    flags_t               flags;
    logic [PL_TAG_W-1:0]  tag;
  } alu_payload_t;

  function automatic flags_t mk_flags(input logic dest_wr, input logic executed,
                                      input logic exc);
    flags_t f;
    f               = '0;
    f[FLAG_DEST_WR] = dest_wr;
    f[FLAG_EXEC]    = executed;
    f[FLAG_EXC]     = exc;
    return f;
  endfunction

endpackage

// File: rtl/simple_alu_pipe_comb.sv
// Pure combinational ALU datapath: opcode + operands -> result, flags.
// ALU_OVF_EXC_EN selects signed-overflow exceptions instead of legacy carry-out.
module simple_alu_comb
  import simple_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OPC_W  = 8
) (
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [IMM_W-1:0]  immd_i,
  output logic [DATA_W-1:0] result_o,
  output flags_t            flags_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0]    imm_sx, imm_zx, add_b, res;
  logic [DATA_W:0]      add_x, sub_x;
  logic [SH_W-1:0]      sh_i, sh_v;
  logic [OPC_PKG_W-1:0] op;
  logic                 opc_hi_ok, add_exc, sub_exc, is_alu, is_nop, exc;

  assign imm_sx    = {{(DATA_W-IMM_W){immd_i[IMM_W-1]}}, immd_i};
  assign imm_zx    = {{(DATA_W-IMM_W){1'b0}}, immd_i};
  assign op        = opcode_i[OPC_PKG_W-1:0];
  // Opcodes wider than the package map are undefined unless the upper bits are zero
  assign opc_hi_ok = (opcode_i >> OPC_PKG_W) == '0;
  assign sh_i      = immd_i[SH_W-1:0];
  assign sh_v      = data1_i[SH_W-1:0];

  assign add_b = (op == OP_ADDI || op == OP_ADDIU) ? imm_sx : data2_i;
  assign add_x = {1'b0, data1_i} + {1'b0, add_b};
  assign sub_x = {1'b0, data1_i} - {1'b0, data2_i};

`ifdef ALU_OVF_EXC_EN
  assign add_exc = (data1_i[DATA_W-1] == add_b[DATA_W-1]) &&
                   (add_x[DATA_W-1] != data1_i[DATA_W-1]);
  assign sub_exc = (data1_i[DATA_W-1] != data2_i[DATA_W-1]) &&
                   (sub_x[DATA_W-1] != data1_i[DATA_W-1]);
`else
  assign add_exc = add_x[DATA_W];
  assign sub_exc = sub_x[DATA_W];
`endif

  always_comb begin
    res    = '0;
    is_alu = 1'b1;
    is_nop = 1'b0;
    exc    = 1'b0;
    case (op)
      OP_NOP:            begin is_alu = 1'b0; is_nop = 1'b1; end
      OP_ADD, OP_ADDI:   begin res = add_x[DATA_W-1:0]; exc = add_exc; end
      OP_ADDU, OP_ADDIU: res = add_x[DATA_W-1:0];
      OP_SUB:            begin res = sub_x[DATA_W-1:0]; exc = sub_exc; end
      OP_SUBU:           res = sub_x[DATA_W-1:0];
      OP_AND:            res = data1_i & data2_i;
      OP_OR:             res = data1_i | data2_i;
      OP_XOR:            res = data1_i ^ data2_i;
      OP_NOR:            res = ~(data1_i | data2_i);
      OP_SLT:            res = DATA_W'($signed(data1_i) < $signed(data2_i));
      OP_SLTU:           res = DATA_W'(data1_i < data2_i);
      OP_SLL:            res = data1_i << sh_i;
      OP_SRL:            res = data1_i >> sh_i;
      OP_SRA:            res = $unsigned($signed(data1_i) >>> sh_i);
      OP_SLLV:           res = data2_i << sh_v;
      OP_SRLV:           res = data2_i >> sh_v;
      OP_SRAV:           res = $unsigned($signed(data2_i) >>> sh_v);
      OP_ANDI:           res = data1_i & imm_zx;
      OP_ORI:            res = data1_i | imm_zx;
      OP_XORI:           res = data1_i ^ imm_zx;
      OP_SLTI:           res = DATA_W'($signed(data1_i) < $signed(imm_sx));
      OP_SLTIU:          res = DATA_W'(data1_i < imm_sx);
      OP_LUI:            res = {immd_i, {(DATA_W-IMM_W){1'b0}}};
      OP_MFHI, OP_MTHI,
      OP_MFLO, OP_MTLO:  res = data1_i;
      default:           is_alu = 1'b0;
    endcase
    if (!opc_hi_ok) begin
      res    = '0;
      is_alu = 1'b0;
      is_nop = 1'b0;
      exc    = 1'b0;
    end
    result_o = res;
    flags_o  = mk_flags(is_alu, is_alu | is_nop, exc);
  end

endmodule

// File: rtl/simple_alu_pipe.sv
// Elastic PIPE_DEPTH-stage ALU pipeline with valid/ready, flush and sync reset.
// Exception semantics follow ALU_OVF_EXC_EN (see simple_alu_comb).
module simple_alu_pipe
  import simple_alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int OPC_W      = 8,
  parameter int TAG_W      = 7,
  parameter int PIPE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [IMM_W-1:0]  immd_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic [5:0]        flags_o,
  output logic [TAG_W-1:0]  tag_o
);

  localparam int LAST = PIPE_DEPTH - 1;

  logic [PIPE_DEPTH-1:0] vld_pipe_q, vld_pipe_d, adv;
  alu_payload_t          pipe_q [PIPE_DEPTH];
  alu_payload_t          pipe_d [PIPE_DEPTH];
  alu_payload_t          in_pl;
  logic [DATA_W-1:0]     alu_res;
  flags_t                alu_flags;
  logic                  s0_free, in_fire;

  simple_alu_comb #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .OPC_W  (OPC_W)
  ) u_alu (
    .opcode_i (opcode_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .immd_i   (immd_i),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  // Walk from the output back: a stage advances when its downstream slot is free
  always_comb begin
    logic free;
    adv  = '0;
    free = out_ready_i;
    for (int k = LAST; k >= 0; k--) begin
      adv[k] = vld_pipe_q[k] & free;
      free   = ~vld_pipe_q[k] | adv[k];
    end
    s0_free = free;
  end

  assign in_ready_o = reset & (flush_i | s0_free);
  assign in_fire    = in_valid_i & in_ready_o & ~flush_i;

  always_comb begin
    in_pl.result = PL_DATA_W'(alu_res);
    in_pl.flags  = alu_flags;
    in_pl.tag    = PL_TAG_W'(tag_i);
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    for (int k = 0; k < PIPE_DEPTH; k++) pipe_d[k] = pipe_q[k];
    for (int k = 0; k < PIPE_DEPTH; k++)
      if (adv[k]) vld_pipe_d[k] = 1'b0;
    if (in_fire) begin
      vld_pipe_d[0] = 1'b1;
      pipe_d[0]     = in_pl;
    end
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      if (adv[k-1]) begin
        vld_pipe_d[k] = 1'b1;
        pipe_d[k]     = pipe_q[k-1];
      end
    end
    if (flush_i) vld_pipe_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) pipe_q[k] <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      for (int k = 0; k < PIPE_DEPTH; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  // Flush wins over a same-cycle output handshake, so hide the valid while it is up
  assign out_valid_o = reset & ~flush_i & vld_pipe_q[LAST];
  assign result_o    = reset ? pipe_q[LAST].result[DATA_W-1:0] : '0;
  assign flags_o     = reset ? pipe_q[LAST].flags : '0;
  assign tag_o       = reset ? pipe_q[LAST].tag[TAG_W-1:0] : '0;

endmodule

// File: tb/tb_simple_alu_pipe.sv
// Directed-vector bench for simple_alu_pipe with an in-order output scoreboard.
module tb_simple_alu_pipe;
  import simple_alu_pkg::*;

  localparam int DATA_W = 32, IMM_W = 16, OPC_W = 8, TAG_W = 7, PIPE_DEPTH = 2;

`ifdef ALU_OVF_EXC_EN
  localparam logic [5:0] FL_ADD_OVF = 6'h16, FL_ADD_CARRY = 6'h14;
`else
  localparam logic [5:0] FL_ADD_OVF = 6'h14, FL_ADD_CARRY = 6'h16;
`endif
  localparam logic [5:0] FL_ALU = 6'h14, FL_NOP = 6'h04;

  logic              clk = 1'b0, reset = 1'b0, flush_i = 1'b0;
  logic              in_valid_i = 1'b0, out_ready_i = 1'b1;
  logic [OPC_W-1:0]  opcode_i = '0;
  logic [DATA_W-1:0] data1_i = '0, data2_i = '0;
  logic [IMM_W-1:0]  immd_i = '0;
  logic [TAG_W-1:0]  tag_i = '0;
  logic              in_ready_o, out_valid_o;
  logic [DATA_W-1:0] result_o;
  logic [5:0]        flags_o;
  logic [TAG_W-1:0]  tag_o;

  simple_alu_pipe #(
    .DATA_W(DATA_W), .IMM_W(IMM_W), .OPC_W(OPC_W), .TAG_W(TAG_W), .PIPE_DEPTH(PIPE_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .opcode_i(opcode_i), .data1_i(data1_i), .data2_i(data2_i),
    .immd_i(immd_i), .tag_i(tag_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .flags_o(flags_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [5:0]        fl;
    logic [TAG_W-1:0]  tag;
  } exp_t;

  int   n_cmp = 0, n_bad = 0, cyc = 0, acc_cnt = 0, out_cnt = 0;
  exp_t exp_q[$];
  int   out_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid_o && out_ready_i) begin
      out_cnt++;
      out_cyc.push_back(cyc);
      chk("out_expected", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_result", result_o, e.res);
        chk("out_flags", flags_o, e.fl);
        chk("out_tag", tag_o, e.tag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] op, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [15:0] imm, input logic [6:0] tg,
                      input logic [31:0] er, input logic [5:0] ef, input bit push);
    int   w;
    bit   done;
    exp_t e;
    w = 0;
    done = 1'b0;
    opcode_i = op; data1_i = d1; data2_i = d2; immd_i = imm; tag_i = tg;
    in_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready_o && !flush_i) begin
        done = 1'b1;
        acc_cnt++;
        if (push) begin
          e.res = er; e.fl = ef; e.tag = tg;
          exp_q.push_back(e);
        end
      end else if (++w > 50) begin
        chk("send_timeout", 64'(w), 0);
        done = 1'b1;
      end
      tick();
    end
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      tick();
      w++;
    end
    chk("drain", 64'(exp_q.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, a0, o0, gaps;

    // reset
    repeat (2) tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_flags", flags_o, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_in_ready", in_ready_o, 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", in_ready_o, 1);
    tick();

    // ADD overflow case and latency
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 16'h0, 7'd5, 32'h8000_0000, FL_ADD_OVF, 1);
    @(negedge clk);
    chk("add_lat_1", out_valid_o, 0);
    tick();
    @(negedge clk);
    chk("add_lat_2", out_valid_o, 1);
    tick();
    drain();

    // back-to-back ADDI stream
    out_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send(OP_ADDI, 32'(i * 256), 32'h0, 16'(i + 1), 7'(16 + i), 32'(i * 256 + i + 1), FL_ALU, 1);
    chk("b2b_cycles", 64'(cyc - c0), 8);
    drain();
    chk("b2b_count", 64'(out_cyc.size()), 8);
    gaps = 0;
    for (int i = 1; i < out_cyc.size(); i++)
      if (out_cyc[i] - out_cyc[i-1] != 1) gaps++;
    chk("b2b_gaps", 64'(gaps), 0);

    // backpressure
    out_ready_i = 1'b0;
    a0 = acc_cnt;
    fork
      for (int i = 0; i < 5; i++)
        send(OP_ADDI, 32'h1000, 32'h0, 16'(i), 7'(40 + i), 32'h1000 + 32'(i), FL_ALU, 1);
      begin
        repeat (3) tick();
        chk("stall_res_c3", result_o, 32'h1000);
        chk("stall_tag_c3", tag_o, 40);
        repeat (2) tick();
        chk("stall_in_ready", in_ready_o, 0);
        chk("stall_accepts", 64'(acc_cnt - a0), PIPE_DEPTH);
        chk("stall_valid", out_valid_o, 1);
        chk("stall_res_c5", result_o, 32'h1000);
        chk("stall_tag_c5", tag_o, 40);
        out_ready_i = 1'b1;
      end
    join
    drain();

    // flush with two in flight and one presented
    o0 = out_cnt;
    send(OP_ADD, 32'd1, 32'd1, 16'h0, 7'd1, 32'h0, 6'h0, 0);
    send(OP_ADD, 32'd2, 32'd2, 16'h0, 7'd2, 32'h0, 6'h0, 0);
    flush_i = 1'b1;
    opcode_i = OP_ADD; data1_i = 32'd3; data2_i = 32'd3; tag_i = 7'd3;
    in_valid_i = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready_o, 1);
    chk("flush_out_valid", out_valid_o, 0);
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    repeat (4) tick();
    chk("flush_no_out", 64'(out_cnt - o0), 0);
    send(OP_SUB, 32'd5, 32'd3, 16'h0, 7'd9, 32'd2, FL_ALU, 1);
    drain();

    // directed datapath vectors
    send(OP_SRA,   32'h8000_0000, 32'h0,         16'h0004, 7'd10, 32'hF800_0000, FL_ALU, 1);
    send(OP_SLTIU, 32'd5,         32'h0,         16'hFFFF, 7'd11, 32'd1,         FL_ALU, 1);
    send(OP_SLT,   32'hFFFF_FFFF, 32'd1,         16'h0,    7'd12, 32'd1,         FL_ALU, 1);
    send(OP_SLTU,  32'hFFFF_FFFF, 32'd1,         16'h0,    7'd13, 32'd0,         FL_ALU, 1);
    send(OP_SUBU,  32'd3,         32'd5,         16'h0,    7'd14, 32'hFFFF_FFFE, FL_ALU, 1);
    send(OP_LUI,   32'h0,         32'h0,         16'h1234, 7'd15, 32'h1234_0000, FL_ALU, 1);
    send(OP_ANDI,  32'hFFFF_FFFF, 32'h0,         16'h8001, 7'd16, 32'h0000_8001, FL_ALU, 1);
    send(OP_XORI,  32'hFFFF_0000, 32'h0,         16'h8000, 7'd17, 32'hFFFF_8000, FL_ALU, 1);
    send(OP_SLLV,  32'h28,        32'h1,         16'h0,    7'd18, 32'h100,       FL_ALU, 1);
    send(OP_SRL,   32'h8000_0000, 32'h0,         16'h0024, 7'd19, 32'h0800_0000, FL_ALU, 1);
    send(OP_XOR,   32'hF0F0,      32'hFF00,      16'h0,    7'd20, 32'h0FF0,      FL_ALU, 1);
    send(OP_NOR,   32'h0,         32'hFFFF_0000, 16'h0,    7'd21, 32'h0000_FFFF, FL_ALU, 1);
    send(OP_MTHI,  32'hDEAD_BEEF, 32'h0,         16'h0,    7'd22, 32'hDEAD_BEEF, FL_ALU, 1);
    send(OP_NOP,   32'd123,       32'd7,         16'h0,    7'd23, 32'h0,         FL_NOP, 1);
    send(8'hFF,    32'd1,         32'd2,         16'h0,    7'd24, 32'h0,         6'h00,  1);
    send(OP_ADDU,  32'h7FFF_FFFF, 32'h1,         16'h0,    7'd25, 32'h8000_0000, FL_ALU, 1);
    send(OP_ADD,   32'hFFFF_FFFF, 32'h1,         16'h0,    7'd26, 32'h0,         FL_ADD_CARRY, 1);
    send(OP_ADDI,  32'h10,        32'h0,         16'hFFFF, 7'd27, 32'hF,         FL_ADD_CARRY, 1);
    drain();

    // reset mid-stream
    out_ready_i = 1'b0;
    send(OP_ADD, 32'd7, 32'd7, 16'h0, 7'd3, 32'h0, 6'h0, 0);
    send(OP_ADD, 32'd8, 32'd8, 16'h0, 7'd4, 32'h0, 6'h0, 0);
    @(negedge clk);
    chk("pre_rst_valid", out_valid_o, 1);
    tick();
    reset = 1'b0;
    out_ready_i = 1'b1;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", out_valid_o, 0);
    chk("rst_mid_result", result_o, 0);
    chk("rst_mid_flags", flags_o, 0);
    chk("rst_mid_tag", tag_o, 0);
    chk("rst_mid_in_ready", in_ready_o, 1);
    o0 = out_cnt;
    repeat (4) tick();
    chk("rst_mid_no_out", 64'(out_cnt - o0), 0);
    send(OP_OR, 32'hA0, 32'h05, 16'h0, 7'd30, 32'hA5, FL_ALU, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
